// File: rtl/c1_bus_slave.sv
`timescale 1ns/1ps
// Cache-side endpoint of the C1 bus: decodes the two-cycle CPU command phase,
// hands one request to the cache core, then drives the RESPONSE phase back.
module c1_bus_slave #(
    parameter int CTR1_W   = 3,
    parameter int ADDR1_W  = 15,
    parameter int DATA_W   = 16,
    parameter int OFFSET_W = 4,
    parameter int ADDR_W   = ADDR1_W + OFFSET_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CTR1_W-1:0]   c1_in,
    output logic [CTR1_W-1:0]   c1_out,
    output logic                c1_oe,
    input  logic [ADDR1_W-1:0]  a1_in,
    input  logic [DATA_W-1:0]   d1_in,
    output logic [DATA_W-1:0]   d1_out,
    output logic                d1_oe,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [CTR1_W-1:0]   req_cmd,
    output logic [ADDR_W-1:0]   req_addr,
    output logic [31:0]         req_wdata,
    input  logic                resp_valid,
    input  logic [31:0]         resp_rdata,
    output logic [31:0]         txn_count,
    output logic [2:0]          state_dbg
);

    localparam logic [CTR1_W-1:0] CMD_NOP    = CTR1_W'(0);
    localparam logic [CTR1_W-1:0] CMD_READ8  = CTR1_W'(1);
    localparam logic [CTR1_W-1:0] CMD_READ16 = CTR1_W'(2);
    localparam logic [CTR1_W-1:0] CMD_READ32 = CTR1_W'(3);
    localparam logic [CTR1_W-1:0] RESPONSE   = CTR1_W'(7);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR2 = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP1 = 3'd4,
        S_RESP2 = 3'd5
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   rdata_hi;
    logic                cmd_is_read;

    assign state_dbg   = state;
    assign cmd_is_read = (req_cmd == CMD_READ8) || (req_cmd == CMD_READ16) ||
                         (req_cmd == CMD_READ32);

    // Request port handshake: req_valid rises one cycle after entering ISSUE
    // (the bus turnaround cycle) and then holds, together with req_cmd/addr/
    // wdata, until sampled with req_ready=1; req_ready is ignored while
    // req_valid is low. The transfer happens on that edge and req_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            c1_oe     <= 1'b0;
            d1_oe     <= 1'b0;
            c1_out    <= '0;
            d1_out    <= '0;
            req_valid <= 1'b0;
            req_cmd   <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            txn_count <= '0;
            rdata_hi  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|c1_in) begin
                        req_cmd                   <= c1_in;
                        req_addr                  <= {a1_in, {OFFSET_W{1'b0}}};
                        req_wdata[DATA_W-1:0]     <= d1_in;
                        req_wdata[31:DATA_W]      <= '0;
                        txn_count                 <= txn_count + 32'd1;
                        state                     <= S_ADDR2;
                    end
                end
                S_ADDR2: begin
                    req_addr[OFFSET_W-1:0]    <= a1_in[OFFSET_W-1:0];
                    req_wdata[DATA_W +: DATA_W] <= d1_in;
                    state                     <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!req_valid) begin
                        req_valid <= 1'b1;
                        c1_oe     <= 1'b1;
                        c1_out    <= CMD_NOP;
                    end else if (req_ready) begin
                        req_valid <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (resp_valid) begin
                        c1_out   <= RESPONSE;
                        d1_oe    <= cmd_is_read;
                        rdata_hi <= resp_rdata[DATA_W +: DATA_W];
                        if (req_cmd == CMD_READ8)
                            d1_out <= {{(DATA_W-8){1'b0}}, resp_rdata[7:0]};
                        else if (cmd_is_read)
                            d1_out <= resp_rdata[DATA_W-1:0];
                        else
                            d1_out <= '0;
                        state    <= S_RESP1;
                    end
                end
                S_RESP1: begin
                    if (req_cmd == CMD_READ32) begin
                        d1_out <= rdata_hi;
                        state  <= S_RESP2;
                    end else begin
                        c1_oe  <= 1'b0;
                        d1_oe  <= 1'b0;
                        c1_out <= CMD_NOP;
                        d1_out <= '0;
                        state  <= S_IDLE;
                    end
                end
                S_RESP2: begin
                    c1_oe  <= 1'b0;
                    d1_oe  <= 1'b0;
                    c1_out <= CMD_NOP;
                    d1_out <= '0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c1_bus_slave.sv
`timescale 1ns/1ps
// Randomized bench for c1_bus_slave: a transaction-level bus model drives the
// CPU/core sides and predicts every output per cycle, plus directed literals.
module tb_c1_bus_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  c1_in, c1_out;
    logic        c1_oe, d1_oe;
    logic [14:0] a1_in;
    logic [15:0] d1_in, d1_out;
    logic        req_valid, req_ready;
    logic [2:0]  req_cmd;
    logic [18:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [31:0] txn_count;
    logic [2:0]  state_dbg;

    c1_bus_slave dut (
        .clk(clk), .rst_n(rst_n),
        .c1_in(c1_in), .c1_out(c1_out), .c1_oe(c1_oe),
        .a1_in(a1_in), .d1_in(d1_in), .d1_out(d1_out), .d1_oe(d1_oe),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .txn_count(txn_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic cmp_en = 1'b0;

    // expected bus state after the most recent edge
    logic        exp_c1_oe = 1'b0, exp_d1_oe = 1'b0, exp_req_valid = 1'b0;
    logic [2:0]  exp_c1_out = 3'd0, exp_req_cmd = 3'd0;
    logic [18:0] exp_req_addr = '0;
    logic [31:0] exp_req_wdata = '0, exp_txn = '0;
    logic [15:0] exp_q[$];

    logic [15:0] d1_log[$];
    int          resp_cyc, rv_cyc, first_resp_cyc, e0_cyc;
    logic [18:0] last_req_addr;
    logic [31:0] last_req_wdata;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("c1_oe", 32'(c1_oe), 32'(exp_c1_oe));
            chk("d1_oe", 32'(d1_oe), 32'(exp_d1_oe));
            chk("req_valid", 32'(req_valid), 32'(exp_req_valid));
            chk("txn_count", txn_count, exp_txn);
            if (exp_c1_oe)
                chk("c1_out", 32'(c1_out), 32'(exp_c1_out));
            if (exp_req_valid) begin
                chk("req_cmd", 32'(req_cmd), 32'(exp_req_cmd));
                chk("req_addr", 32'(req_addr), 32'(exp_req_addr));
                chk("req_wdata", req_wdata, exp_req_wdata);
            end
            if (!rst_n) begin
                chk("rst_c1_out", 32'(c1_out), 32'd0);
                chk("rst_d1_out", 32'(d1_out), 32'd0);
                chk("rst_req_cmd", 32'(req_cmd), 32'd0);
                chk("rst_req_addr", 32'(req_addr), 32'd0);
                chk("rst_req_wdata", req_wdata, 32'd0);
            end
            if (d1_oe) begin
                d1_log.push_back(d1_out);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL d1_beat: got 0x%0h expected no beat at t=%0t", d1_out, $time);
                end else begin
                    chk("d1_beat", 32'(d1_out), 32'(exp_q.pop_front()));
                end
            end
            if (c1_oe && c1_out == 3'd7) begin
                if (resp_cyc == 0) first_resp_cyc = cyc;
                resp_cyc++;
            end
            if (req_valid) begin
                rv_cyc++;
                last_req_addr  = req_addr;
                last_req_wdata = req_wdata;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at t=%0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        d1_log.delete();
        resp_cyc = 0;
        rv_cyc = 0;
        first_resp_cyc = -1;
    endtask

    // random bus activity while the slave is not listening
    task automatic junk(input bit allow_resp);
        c1_in      = 3'($urandom_range(0, 7));
        a1_in      = 15'($urandom);
        d1_in      = 16'($urandom);
        resp_valid = allow_resp ? 1'($urandom_range(0, 1)) : 1'b0;
        resp_rdata = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            c1_in      = 3'd0;
            a1_in      = 15'($urandom);
            d1_in      = 16'($urandom);
            resp_valid = 1'($urandom_range(0, 1));
            resp_rdata = $urandom;
            req_ready  = 1'($urandom_range(0, 1));
            tick();
        end
        resp_valid = 1'b0;
        req_ready  = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        exp_c1_oe = 1'b0;
        exp_d1_oe = 1'b0;
        exp_req_valid = 1'b0;
        exp_txn = '0;
        #1;
        chk("async_rst_c1_oe", 32'(c1_oe), 32'd0);
        chk("async_rst_d1_oe", 32'(d1_oe), 32'd0);
        chk("async_rst_req_valid", 32'(req_valid), 32'd0);
        chk("async_rst_txn", txn_count, 32'd0);
        chk("async_rst_c1_out", 32'(c1_out), 32'd0);
        chk("async_rst_d1_out", 32'(d1_out), 32'd0);
        chk("async_rst_req_addr", 32'(req_addr), 32'd0);
        c1_in = 3'd0;
        resp_valid = 1'b0;
        req_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One full C1 transaction; rdly = req_ready-low cycles while req_valid is
    // up, vdly = extra WAIT cycles before resp_valid.
    task automatic do_txn(input logic [2:0] cmd, input logic [14:0] ts, input logic [3:0] off,
                          input logic [15:0] dlo, input logic [15:0] dhi,
                          input int rdly, input int vdly, input logic [31:0] rd, input bit abort);
        c1_in = cmd; a1_in = ts; d1_in = dlo;
        resp_valid = 1'b0; req_ready = 1'($urandom_range(0, 1));
        tick();                                   // E0: command sampled
        e0_cyc = cyc;
        exp_txn = exp_txn + 32'd1;
        c1_in = cmd; a1_in = {11'($urandom), off}; d1_in = dhi;
        resp_valid = 1'($urandom_range(0, 1)); resp_rdata = $urandom;
        tick();                                   // E1: offset and high data
        exp_req_cmd = cmd;
        exp_req_addr = {ts, off};
        exp_req_wdata = {dhi, dlo};
        junk(1); req_ready = 1'b0;
        tick();                                   // E2: request and C1 drive up
        exp_req_valid = 1'b1;
        exp_c1_oe = 1'b1;
        exp_c1_out = 3'd0;
        for (int i = 0; i < rdly; i++) begin
            junk(1); req_ready = 1'b0;
            tick();
        end
        junk(1); req_ready = 1'b1;
        tick();                                   // handshake
        exp_req_valid = 1'b0;
        if (abort) begin
            for (int i = 0; i < vdly; i++) begin
                junk(0); req_ready = 1'($urandom_range(0, 1));
                tick();
            end
            do_reset();
            return;
        end
        for (int i = 0; i < vdly; i++) begin
            junk(0); req_ready = 1'($urandom_range(0, 1));
            tick();
        end
        junk(0); resp_valid = 1'b1; resp_rdata = rd;
        tick();                                   // response accepted
        exp_c1_out = 3'd7;
        exp_d1_oe = (cmd >= 3'd1) && (cmd <= 3'd3);
        if (cmd == 3'd1) exp_q.push_back({8'h00, rd[7:0]});
        else if (cmd == 3'd2 || cmd == 3'd3) exp_q.push_back(rd[15:0]);
        if (cmd == 3'd3) exp_q.push_back(rd[31:16]);
        junk(1);
        if (cmd == 3'd3) begin
            tick();
            junk(1);
        end
        tick();                                   // bus released
        exp_c1_oe = 1'b0;
        exp_d1_oe = 1'b0;
        exp_c1_out = 3'd0;
        c1_in = 3'd0; resp_valid = 1'b0; req_ready = 1'b0;
    endtask

    initial begin
        c1_in = '0; a1_in = '0; d1_in = '0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        tick();
        rst_n = 1'b1;
        idle_cycles(3);

        // READ32 with immediate ready
        clear_logs();
        do_txn(3'd3, 15'd1337, 4'd8, 16'h0BAD, 16'hF00D, 0, 0, 32'hDEADBEEF, 1'b0);
        chk("r32_req_addr", 32'(last_req_addr), 32'h0000_5398);
        chk("r32_latency", 32'(first_resp_cyc - e0_cyc), 32'd4);
        chk("r32_resp_cycles", 32'(resp_cyc), 32'd2);
        chk("r32_beat_count", 32'(d1_log.size()), 32'd2);
        if (d1_log.size() == 2) begin
            chk("r32_beat0", 32'(d1_log[0]), 32'h0000_BEEF);
            chk("r32_beat1", 32'(d1_log[1]), 32'h0000_DEAD);
        end
        chk("r32_txn", txn_count, 32'd1);
        idle_cycles(2);

        // reset while waiting for the core, then a stale core response
        clear_logs();
        do_txn(3'd2, 15'($urandom), 4'($urandom), 16'h1111, 16'h2222, 0, 1, 32'h0, 1'b1);
        resp_valid = 1'b1; resp_rdata = 32'h0BAD_0BAD;
        tick();
        tick();
        resp_valid = 1'b0;
        tick();
        chk("rst_txn", txn_count, 32'd0);
        chk("rst_stale_resp", 32'(resp_cyc), 32'd0);

        // back-to-back INVALIDATE_LINE then READ16
        clear_logs();
        do_txn(3'd4, 15'h7ABC, 4'h3, 16'h0, 16'h0, 1, 2, 32'h5555_AAAA, 1'b0);
        do_txn(3'd2, 15'h0042, 4'hF, 16'h0, 16'h0, 0, 3, 32'hCAFE_1234, 1'b0);
        chk("b2b_txn", txn_count, 32'd2);
        chk("b2b_resp_cycles", 32'(resp_cyc), 32'd2);
        chk("b2b_beat_count", 32'(d1_log.size()), 32'd1);
        if (d1_log.size() == 1) chk("b2b_r16", 32'(d1_log[0]), 32'h0000_1234);
        idle_cycles(1);

        // WRITE32 with a stalled core
        clear_logs();
        do_txn(3'd7, 15'h1234, 4'h5, 16'h5678, 16'h1234, 5, 0, 32'hFFFF_FFFF, 1'b0);
        chk("w32_wdata", last_req_wdata, 32'h1234_5678);
        chk("w32_latency", 32'(first_resp_cyc - e0_cyc), 32'd9);
        chk("w32_resp_cycles", 32'(resp_cyc), 32'd1);
        chk("w32_no_d1", 32'(d1_log.size()), 32'd0);

        // READ8 zero-extension
        clear_logs();
        do_txn(3'd1, 15'h0001, 4'h0, 16'h0, 16'h0, 0, 0, 32'hFFFF_FFA5, 1'b0);
        chk("r8_resp_cycles", 32'(resp_cyc), 32'd1);
        chk("r8_beat_count", 32'(d1_log.size()), 32'd1);
        if (d1_log.size() == 1) chk("r8_beat", 32'(d1_log[0]), 32'h0000_00A5);

        for (int n = 0; n < 50; n++) begin
            logic [2:0] cmd;
            cmd = 3'($urandom_range(1, 7));
            do_txn(cmd, 15'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                   ($urandom_range(0, 15) == 0));
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(3);
        chk("beats_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
